// File: rtl/thread_scheduler_pkg.sv
// Shared definitions for the thread scheduler: FSM encodings and the
// per-thread PC base-address helper.
package thread_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sched_state_e;

  // Each thread owns an equal slice of instruction memory; its PC starts at the slice base.
  function automatic logic [31:0] pc_base(input int tid, input int addr_w, input int tid_bits);
    logic [31:0] t;
    t = 32'(tid);
    return t << (addr_w - tid_bits);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: grants the first requester after last_i,
// scanning upward and wrapping. Shared with the memory arbiter.
module rr_picker #(
  parameter int W = 2,
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] grant_o,
  output logic         valid_o
);

  logic [W-1:0] idx_s;

  // Scan from the farthest offset down so the nearest requester after last_i wins.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx_s   = '0;
    for (int k = N; k >= 1; k--) begin
      idx_s = last_i + W'(k);
      if (req_i[idx_s]) begin
        grant_o = idx_s;
        valid_o = 1'b1;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/thread_scheduler.sv
// Fine-grained round-robin scheduler for the 4-thread core.
// Optional per-thread issue counters are enabled with SCHED_PERF_CNT_EN.
module thread_scheduler
  import thread_scheduler_pkg::*;
#(
  parameter int INST_ADDR_WIDTH = 9,
  parameter int THREAD_BITS     = 2,
  parameter int NUM_THREADS     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stall,
  input  logic [NUM_THREADS-1:0]     thread_done,
  input  logic                       br_valid,
  input  logic [THREAD_BITS-1:0]     br_tid,
  input  logic [INST_ADDR_WIDTH-1:0] br_target,
`ifdef SCHED_PERF_CNT_EN
  input  logic [THREAD_BITS-1:0]     perf_sel,
  output logic [31:0]                perf_count,
`endif
  output logic                       issue_valid,
  output logic [THREAD_BITS-1:0]     thread_id,
  output logic [INST_ADDR_WIDTH-1:0] pc_out,
  output logic [NUM_THREADS-1:0]     active_mask,
  output logic                       all_done
);

  localparam int AW = INST_ADDR_WIDTH;
  localparam int TB = THREAD_BITS;
  localparam int NT = NUM_THREADS;

  sched_state_e  state_q, state_d;
  logic [AW-1:0] pc_q [NT];
  logic [AW-1:0] pc_d [NT];
  logic [NT-1:0] mask_q, mask_d;
  logic [TB-1:0] last_q, last_d;
  logic          iv_q, iv_d;
  logic [TB-1:0] tid_q, tid_d;
  logic [AW-1:0] pcout_q, pcout_d;
  logic          done_q, done_d;
  logic [TB-1:0] grant_s;
  logic          grant_valid_s;

  rr_picker #(.W(TB), .N(NT)) u_picker (
    .req_i   (mask_q),
    .last_i  (last_q),
    .grant_o (grant_s),
    .valid_o (grant_valid_s)
  );

  // Next-state logic: FSM, selection, PC update, halt mask and redirects.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    last_d  = last_q;
    iv_d    = 1'b0;
    tid_d   = tid_q;
    pcout_d = pcout_q;
    done_d  = done_q;
    for (int i = 0; i < NT; i++) pc_d[i] = pc_q[i];

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          mask_d  = '1;
          done_d  = 1'b0;
          last_d  = TB'(NT - 1);
          for (int i = 0; i < NT; i++) pc_d[i] = AW'(pc_base(i, AW, TB));
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        if (mask_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (!stall && grant_valid_s) begin
          iv_d             = 1'b1;
          tid_d            = grant_s;
          pcout_d          = pc_q[grant_s];
          pc_d[grant_s]    = pc_q[grant_s] + AW'(1);
          last_d           = grant_s;
        end else begin
          iv_d = 1'b0;
        end
        mask_d = mask_q & ~thread_done;
        // Redirect overrides the post-issue increment on the same thread.
        if (br_valid) begin
          pc_d[br_tid] = br_target;
        end else begin
          pc_d[br_tid] = pc_d[br_tid];
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      last_q  <= TB'(NT - 1);
      iv_q    <= 1'b0;
      tid_q   <= '0;
      pcout_q <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < NT; i++) pc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      last_q  <= last_d;
      iv_q    <= iv_d;
      tid_q   <= tid_d;
      pcout_q <= pcout_d;
      done_q  <= done_d;
      for (int i = 0; i < NT; i++) pc_q[i] <= pc_d[i];
    end
  end

  assign issue_valid = iv_q;
  assign thread_id   = tid_q;
  assign pc_out      = pcout_q;
  assign active_mask = mask_q;
  assign all_done    = done_q;

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] cnt_q [NT];

  // Saturating per-thread issue counters, cleared on each launch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NT; i++) cnt_q[i] <= 32'd0;
    end else if (start && (state_q != S_RUN)) begin
      for (int i = 0; i < NT; i++) cnt_q[i] <= 32'd0;
    end else if (iv_d && (cnt_q[tid_d] != 32'hFFFF_FFFF)) begin
      cnt_q[tid_d] <= cnt_q[tid_d] + 32'd1;
    end else begin
      cnt_q[tid_d] <= cnt_q[tid_d];
    end
  end

  assign perf_count = cnt_q[perf_sel];
`endif

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed table-driven bench for thread_scheduler plus hand-written reset sequences.
module tb_thread_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stall;
  logic [3:0] thread_done;
  logic       br_valid;
  logic [1:0] br_tid;
  logic [8:0] br_target;
  logic       issue_valid;
  logic [1:0] thread_id;
  logic [8:0] pc_out;
  logic [3:0] active_mask;
  logic       all_done;
`ifdef SCHED_PERF_CNT_EN
  logic [1:0]  perf_sel = 2'd0;
  logic [31:0] perf_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  thread_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stall       (stall),
    .thread_done (thread_done),
    .br_valid    (br_valid),
    .br_tid      (br_tid),
    .br_target   (br_target),
`ifdef SCHED_PERF_CNT_EN
    .perf_sel    (perf_sel),
    .perf_count  (perf_count),
`endif
    .issue_valid (issue_valid),
    .thread_id   (thread_id),
    .pc_out      (pc_out),
    .active_mask (active_mask),
    .all_done    (all_done)
  );

  typedef struct {
    logic       st;
    logic       sl;
    logic [3:0] dn;
    logic       bv;
    logic [1:0] bt;
    logic [8:0] btg;
    logic       iv;
    logic [1:0] tid;
    logic [8:0] pc;
    logic [3:0] mask;
    logic       ad;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic sl, input logic [3:0] dn,
                     input logic bv, input logic [1:0] bt, input logic [8:0] btg,
                     input logic iv, input logic [1:0] tid, input logic [8:0] pc,
                     input logic [3:0] mask, input logic ad);
    vec_t v;
    v.st = st; v.sl = sl; v.dn = dn; v.bv = bv; v.bt = bt; v.btg = btg;
    v.iv = iv; v.tid = tid; v.pc = pc; v.mask = mask; v.ad = ad;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic iv, input logic [1:0] tid,
                       input logic [8:0] pc, input logic [3:0] mask, input logic ad);
    n_tests++;
    if ({issue_valid, thread_id, pc_out, active_mask, all_done} !== {iv, tid, pc, mask, ad}) begin
      n_fail++;
      $display("FAIL %s: got iv=%b tid=%0d pc=%0d mask=%b done=%b, want iv=%b tid=%0d pc=%0d mask=%b done=%b",
               name, issue_valid, thread_id, pc_out, active_mask, all_done, iv, tid, pc, mask, ad);
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0; stall = 1'b0; thread_done = 4'b0000;
    br_valid = 1'b0; br_tid = 2'd0; br_target = 9'd0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    #3;
    check("reset_state", 1'b0, 2'd0, 9'd0, 4'b0000, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_quiet", 1'b0, 2'd0, 9'd0, 4'b0000, 1'b0);

    //   st    sl    done     bv    bt    btg      iv    tid   pc       mask     ad
    add(1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 9'h000, 1'b0, 2'd0, 9'd0,   4'b1111, 1'b0);
    add(1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 9'h000, 1'b1, 2'd0, 9'd0,   4'b1111, 1'b0);
    add(1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 9'h000, 1'b1, 2'd1, 9'd128, 4'b1111, 1'b0);
    add(1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 9'h000, 1'b1, 2'd2, 9'd256, 4'b1111, 1'b0);
    add(1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 9'h000, 1'b1, 2'd3, 9'd384, 4'b1111, 1'b0);
    add(1'b0, 1'b0, 4'b0100, 1'b0, 2'd0, 9'h000, 1'b1, 2'd0, 9'd1,   4'b1011, 1'b0);
    add(1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 9'h050, 1'b1, 2'd1, 9'd129, 4'b1011, 1'b0);
    add(1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 9'h000, 1'b1, 2'd3, 9'd385, 4'b1011, 1'b0);
    add(1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 9'h000, 1'b1, 2'd0, 9'd2,   4'b1011, 1'b0);
    add(1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 9'h000, 1'b1, 2'd1, 9'h050, 4'b1011, 1'b0);
    add(1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 9'h000, 1'b1, 2'd3, 9'd386, 4'b1011, 1'b0);
    add(1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 9'h000, 1'b0, 2'd3, 9'd386, 4'b1011, 1'b0);
    add(1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 9'h000, 1'b0, 2'd3, 9'd386, 4'b1011, 1'b0);
    add(1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 9'h000, 1'b0, 2'd3, 9'd386, 4'b1011, 1'b0);
    add(1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 9'h000, 1'b1, 2'd0, 9'd3,   4'b1011, 1'b0);
    add(1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 9'h000, 1'b1, 2'd1, 9'h051, 4'b1011, 1'b0);
    add(1'b0, 1'b0, 4'b0001, 1'b0, 2'd0, 9'h000, 1'b1, 2'd3, 9'd387, 4'b1010, 1'b0);
    add(1'b0, 1'b0, 4'b1010, 1'b0, 2'd0, 9'h000, 1'b1, 2'd1, 9'd82,  4'b0000, 1'b0);
    add(1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 9'h000, 1'b0, 2'd1, 9'd82,  4'b0000, 1'b1);
    add(1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 9'h000, 1'b0, 2'd1, 9'd82,  4'b0000, 1'b1);
    add(1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 9'h000, 1'b0, 2'd1, 9'd82,  4'b1111, 1'b0);
    add(1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 9'h000, 1'b1, 2'd0, 9'd0,   4'b1111, 1'b0);
    add(1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 9'h000, 1'b1, 2'd1, 9'd128, 4'b1111, 1'b0);
    add(1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 9'h000, 1'b1, 2'd2, 9'd256, 4'b1111, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].st; stall = vecs[i].sl; thread_done = vecs[i].dn;
      br_valid = vecs[i].bv; br_tid = vecs[i].bt; br_target = vecs[i].btg;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), vecs[i].iv, vecs[i].tid, vecs[i].pc, vecs[i].mask, vecs[i].ad);
    end
    idle_inputs();

    // Mid-run reset must clear outputs without waiting for a clock edge.
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", 1'b0, 2'd0, 9'd0, 4'b0000, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_idle", 1'b0, 2'd0, 9'd0, 4'b0000, 1'b0);

    // Single active thread is issued back to back after a relaunch.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    thread_done = 4'b1101;
    @(posedge clk); #1;
    thread_done = 4'b0000;
    check("relaunch_first", 1'b1, 2'd0, 9'd0, 4'b0010, 1'b0);
    @(posedge clk); #1;
    check("single_a", 1'b1, 2'd1, 9'd128, 4'b0010, 1'b0);
    @(posedge clk); #1;
    check("single_b", 1'b1, 2'd1, 9'd129, 4'b0010, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
